// File: rtl/seq_checker.sv
// seq_checker: checks a player's button presses against a latched
// sequence of up to five button IDs. It reports each correct press,
// a wrong press or a press timeout, and completion of the whole sequence.
module seq_checker #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] stage,
    input  logic [9:0] pattern,
    input  logic       start,
    input  logic [3:0] btn,
    output logic       true_stack,
    output logic       fail,
    output logic       done,
    output logic       active,
    output logic [2:0] idx
);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] S_WAIT_RELEASE = 2'd2;

    // Timer value at which an idle WAIT_PRESS cycle becomes a miss.
    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [1:0]  r_state;
    logic [9:0]  r_pat;
    logic [2:0]  r_n;
    logic [2:0]  r_idx;
    logic [15:0] r_timer;
    logic        r_true_stack;
    logic        r_fail;
    logic        r_done;
    logic        r_active;

    logic [2:0]  w_n;
    logic [1:0]  w_entry;
    logic [1:0]  w_btn_id;
    logic        w_onehot;
    logic        w_match;

    // Sequence length, expected entry and decoded button for this cycle.
    always_comb begin
        w_n = 3'(stage[0]) + 3'(stage[1]) + 3'(stage[2])
            + 3'(stage[3]) + 3'(stage[4]);

        w_entry = 2'd0;
        case (r_idx)
            3'd0:    w_entry = r_pat[1:0];
            3'd1:    w_entry = r_pat[3:2];
            3'd2:    w_entry = r_pat[5:4];
            3'd3:    w_entry = r_pat[7:6];
            3'd4:    w_entry = r_pat[9:8];
            default: w_entry = 2'd0;
        endcase

        // Anything other than exactly one pressed button is never a match.
        w_btn_id = 2'd0;
        w_onehot = 1'b1;
        case (btn)
            4'b0001: w_btn_id = 2'd0;
            4'b0010: w_btn_id = 2'd1;
            4'b0100: w_btn_id = 2'd2;
            4'b1000: w_btn_id = 2'd3;
            default: w_onehot = 1'b0;
        endcase

        w_match = w_onehot && (w_btn_id == w_entry);
    end

    // Main FSM; every output is a flop so pulses are glitch-free.
    // The first WAIT_RELEASE cycle (flagged by the true_stack pulse still
    // being high) never looks at btn, which guarantees two quiet cycles
    // between consecutive true_stack pulses even for a one-cycle tap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pat        <= '0;
            r_n          <= '0;
            r_idx        <= '0;
            r_timer      <= '0;
            r_true_stack <= 1'b0;
            r_fail       <= 1'b0;
            r_done       <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_true_stack <= 1'b0;
            r_fail       <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && (w_n != 3'd0)) begin
                        r_pat    <= pattern;
                        r_n      <= w_n;
                        r_idx    <= '0;
                        r_timer  <= '0;
                        r_state  <= S_WAIT_PRESS;
                        r_active <= 1'b1;
                    end
                end
                S_WAIT_PRESS: begin
                    if (btn == 4'b0000) begin
                        if (r_timer == LP_TMO_LAST) begin
                            r_fail   <= 1'b1;
                            r_state  <= S_IDLE;
                            r_active <= 1'b0;
                        end else if (r_timer != 16'hFFFF) begin
                            r_timer <= r_timer + 16'd1;
                        end
                    end else if (w_match) begin
                        r_true_stack <= 1'b1;
                        r_idx        <= r_idx + 3'd1;
                        r_state      <= S_WAIT_RELEASE;
                    end else begin
                        r_fail   <= 1'b1;
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (!r_true_stack && (btn == 4'b0000)) begin
                        if (r_idx == r_n) begin
                            r_done   <= 1'b1;
                            r_state  <= S_IDLE;
                            r_active <= 1'b0;
                        end else begin
                            r_timer <= '0;
                            r_state <= S_WAIT_PRESS;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign true_stack = r_true_stack;
    assign fail       = r_fail;
    assign done       = r_done;
    assign active     = r_active;
    assign idx        = r_idx;

endmodule
